md_sequencer: RTL
=================

# md_sequencer

Multi-cycle multiply/divide sequencer and HI/LO register owner for the pipelined MIPS core. It sits beside the EX-stage ALU and accepts the decoder's `MulOp`, `MTHILO` and `MFHILO` codes. It runs each operation for a fixed cycle count and commits results to HI/LO. It raises a stall while a HI/LO-dependent instruction would observe an unfinished result.

## Interface
Parameters:
- `MUL_CYCLES`, default 5: busy cycles for MULT/MULTU/MADD/MADDU/MSUB/MSUBU; legal range 1–31.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU; legal range 1–31.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mul_op`  in  4  operation code:
  - 0 MULTU, 1 MULT, 2 DIVU, 3 DIV
  - 4 MADDU, 5 MADD, 6 MSUBU, 7 MSUB
  - 8–15 none
- `mthilo`  in  2  00 MTLO, 01 MTHI, 10/11 none.
- `mfhilo`  in  2  01 MFLO, 10 MFHI, 00/11 none.
- `rs_data`  in  32  operand A; also the MTHI/MTLO source.
- `rt_data`  in  32  operand B.
- `md_stall`  out  1  hold the EX instruction and upstream stages.
- `busy`  out  1  operation in flight.
- `hilo_rdata`  out  32  HI or LO as selected by `mfhilo`; 0 when `mfhilo` is none.

## Operation
- **FSM states:**
  - IDLE → BUSY on an accepted `mul_op` < 8.
  - BUSY → IDLE when the counter reaches 0; the commit happens on that edge.
- **Request:** any cycle with `mul_op` < 8, or `mthilo` ∈ {00, 01}, or `mfhilo` ∈ {01, 10}.
- **Stall:** `md_stall` = `busy` AND request. This is combinational; the pipeline holds its inputs stable while stalled.
- **Accept (IDLE, request present, not stalled):**
  - `mul_op` < 8: latch `rs_data`, `rt_data` and the op. Load the counter with (`MUL_CYCLES` or `DIV_CYCLES`) − 1.
  - `mthilo` = 00: LO ← `rs_data`. `mthilo` = 01: HI ← `rs_data`. Written on the edge; no busy period.
  - Priority: `mul_op` over `mthilo`. Decode never asserts both; the tie rule is for determinism only.
- **BUSY:** the counter decrements each cycle. Operand latches, HI and LO are frozen.
- **Arithmetic at commit, all 64-bit with wrap:**
  - MULT: {HI,LO} = signed A × signed B. MULTU: unsigned product.
  - MADD/MADDU: {HI,LO} = {HI,LO} + product. MSUB/MSUBU: {HI,LO} = {HI,LO} − product. Signedness matches the op's product.
  - DIV: LO = quotient, HI = remainder. Quotient truncates toward zero; remainder takes the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (B = 0): LO = 32'hFFFF_FFFF, HI = A. Applies to both DIV and DIVU.
  - DIV of 32'h8000_0000 by 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0.
- **Read:** `hilo_rdata` is a combinational read of the HI/LO registers. It is meaningful only when `md_stall` = 0.
- **Reset (asserted at any time, including mid-operation):**
  - HI, LO, counter and operand latches clear to 0.
  - State → IDLE; `busy` = 0, `md_stall` = 0.
  - Any in-flight result is discarded.

## Timing
- Issue in cycle t (IDLE, accepted): `busy` = 1 in cycles t+1 … t+N, where N = `MUL_CYCLES` or `DIV_CYCLES`.
- HI/LO are written on the edge ending cycle t+N. In t+N+1, `busy` = 0 and MFHI/MFLO read the new value.
- A dependent request presented in t+1 … t+N sees `md_stall` = 1 for every one of those cycles. It is accepted in t+N+1.
- Back-to-back ops: the second op is stalled until t+N+1, then issues. There is no overlap.
- A request in the same cycle as the commit edge (cycle t+N) is stalled. It proceeds in t+N+1 and sees the committed result.
- MTHI/MTLO in IDLE: the write takes effect on that edge; MFHI/MFLO in the next cycle reads it.
- Non-HI/LO instructions never stall, even while `busy` = 1.

## Test plan
- **Reset:** deassert `reset_n` → HI = LO = 0, `busy` = 0, `md_stall` = 0. MFHI reads 0.
- **MULT timing:** MULT A = 32'hFFFF_FFFE (−2), B = 3 → `busy` high for 5 cycles. MFLO presented at t+1 stalls through t+5. At t+6 it reads LO = 32'hFFFF_FFFA, and HI = 32'hFFFF_FFFF.
- **DIV cases, each checked against 10 busy cycles:**
  - DIV −7 / 2 → LO = 32'hFFFF_FFFD, HI = 32'hFFFF_FFFF.
  - DIVU 7 / 0 → LO = 32'hFFFF_FFFF, HI = 7.
  - DIV 32'h8000_0000 / −1 → LO = 32'h8000_0000, HI = 0.
- **MADDU with carry:** MTHI 0, MTLO 32'hFFFF_FFFF, then MADDU 1 × 1 → HI = 1, LO = 0.
- **Back-to-back ops:** MULTU 2×3 followed by DIVU 9/2 → DIVU stalls exactly 5 cycles, then runs 10. Final LO = 4, HI = 1.
- **Reset mid-operation:** pulse `reset_n` low at cycle 4 of a DIV → `busy` drops immediately and HI = LO = 0. A subsequent MFLO returns 0 with no stall.

Source files
------------

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer that owns the HI/LO registers.
// Results commit on the edge that ends the busy period; HI/LO-dependent requests stall until then.
module md_sequencer #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  mul_op,
    input  logic [1:0]  mthilo,
    input  logic [1:0]  mfhilo,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        md_stall,
    output logic        busy,
    output logic [31:0] hilo_rdata
);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        mul_req;
    logic        mt_req;
    logic        mf_req;

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [63:0] result;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quot_mag;
    logic [31:0] rem_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign mul_req    = ~mul_op[3];
    assign mt_req     = ~mthilo[1];
    assign mf_req     = ^mfhilo;
    assign busy       = (state_q == ST_BUSY);
    assign md_stall   = busy & (mul_req | mt_req | mf_req);
    assign hilo_rdata = (mfhilo == 2'b01) ? lo_q : ((mfhilo == 2'b10) ? hi_q : 32'h0);

    // Odd op codes are the signed variants; the low 64 bits of a sign-extended
    // 64x64 product equal the signed 32x32 product.
    always_comb begin
        ext_a   = op_q[0] ? {{32{a_q[31]}}, a_q} : {32'h0, a_q};
        ext_b   = op_q[0] ? {{32{b_q[31]}}, b_q} : {32'h0, b_q};
        product = ext_a * ext_b;
    end

    always_comb begin
        a_neg    = op_q[0] & a_q[31];
        b_neg    = op_q[0] & b_q[31];
        mag_a    = a_neg ? (32'h0 - a_q) : a_q;
        mag_b    = b_neg ? (32'h0 - b_q) : b_q;
        quot_mag = 32'h0;
        rem_mag  = 32'h0;
        if (mag_b != 32'h0) begin
            quot_mag = mag_a / mag_b;
            rem_mag  = mag_a % mag_b;
        end
        // 0x8000_0000 / -1 wraps naturally back to 0x8000_0000 with remainder 0.
        quot = (a_neg ^ b_neg) ? (32'h0 - quot_mag) : quot_mag;
        rem  = a_neg ? (32'h0 - rem_mag) : rem_mag;
    end

    always_comb begin
        result = {hi_q, lo_q};
        case (op_q[2:1])
            2'b00: result = product;
            2'b01: result = (b_q == 32'h0) ? {a_q, 32'hFFFF_FFFF} : {rem, quot};
            2'b10: result = {hi_q, lo_q} + product;
            2'b11: result = {hi_q, lo_q} - product;
            default: result = {hi_q, lo_q};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (mul_req) begin
                    op_d    = mul_op[2:0];
                    a_d     = rs_data;
                    b_d     = rt_data;
                    cnt_d   = (mul_op[2:1] == 2'b01) ? DIV_LOAD : MUL_LOAD;
                    state_d = ST_BUSY;
                end else if (mt_req) begin
                    if (mthilo[0]) begin
                        hi_d = rs_data;
                    end else begin
                        lo_d = rs_data;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == 5'd0) begin
                    hi_d    = result[63:32];
                    lo_d    = result[31:0];
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 3'd0;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            hi_q    <= 32'h0;
            lo_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule
